cr_iu_wb_arb: RTL and testbench

GPR write-port arbiter and fast-retired-load tracker for the E902 IU. It sits between the IU result bus and the register file. It shares the single GPR write port between EX-stage completions and late LSU load returns, holds at most one outstanding fast-retired load, and stalls EX on register hazards or port conflicts against that load.

---
 rtl/cr_iu_wb_arb.sv | 122 ++++++++++++
 tb/tb_cr_iu_wb_arb.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_iu_wb_arb.sv
// GPR write-port arbiter for the IU result bus and late LSU load returns.
// It tracks one fast-retired load and stalls EX on hazards or port conflicts.
module cr_iu_wb_arb (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        rbus_wb_cmplt,
    input  logic [31:0] rbus_wb_data,
    input  logic [4:0]  rbus_wb_dst_reg,
    input  logic        rbus_wb_load,
    input  logic        ex_inst_vld,
    input  logic        ex_rs1_vld,
    input  logic        ex_rs2_vld,
    input  logic        ex_rd_vld,
    input  logic [4:0]  ex_rs1_reg,
    input  logic [4:0]  ex_rs2_reg,
    input  logic        lsu_wb_data_vld,
    input  logic [31:0] lsu_wb_data,
    input  logic        lsu_wb_acc_err,
    output logic        wb_rf_wen,
    output logic [4:0]  wb_rf_waddr,
    output logic [31:0] wb_rf_wdata,
    output logic        wb_ex_stall,
    output logic        wb_ld_pending,
    output logic        wb_acc_err_pulse
);

    typedef enum logic [1:0] {IDLE, LD_WAIT, HOLD} state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  ld_dst;
    logic [31:0] hold_data;
    logic        hit;
    logic        rbus_acc;
    logic        wen_raw;
    logic [4:0]  waddr_raw;
    logic [31:0] wdata_raw;
    logic        ld_dst_set;
    logic        hold_set;
    logic        err_raw;
    logic        wen_ok;

    // Stall never looks at lsu_wb_data_vld, so the LSU handshake has no loop.
    assign hit = ex_inst_vld & ((ex_rs1_vld & (ex_rs1_reg == ld_dst)) |
                                (ex_rs2_vld & (ex_rs2_reg == ld_dst)) |
                                (ex_rd_vld  & (rbus_wb_dst_reg == ld_dst)));
    assign wb_ex_stall = (state != IDLE) &
                         (hit | rbus_wb_load | ((state == HOLD) & rbus_wb_cmplt));
    assign rbus_acc = rbus_wb_cmplt & ~wb_ex_stall;

    always_comb begin
        next_state = state;
        wen_raw    = 1'b0;
        waddr_raw  = 5'd0;
        wdata_raw  = 32'd0;
        ld_dst_set = 1'b0;
        hold_set   = 1'b0;
        err_raw    = 1'b0;
        case (state)
            IDLE: begin
                if (rbus_acc && rbus_wb_load) begin
                    ld_dst_set = 1'b1;
                    next_state = LD_WAIT;
                end else if (rbus_acc) begin
                    wen_raw   = 1'b1;
                    waddr_raw = rbus_wb_dst_reg;
                    wdata_raw = rbus_wb_data;
                end
            end
            LD_WAIT: begin
                if (lsu_wb_data_vld && lsu_wb_acc_err) begin
                    err_raw    = 1'b1;
                    next_state = IDLE;
                end else if (lsu_wb_data_vld && !rbus_acc) begin
                    wen_raw    = 1'b1;
                    waddr_raw  = ld_dst;
                    wdata_raw  = lsu_wb_data;
                    next_state = IDLE;
                end else if (lsu_wb_data_vld) begin
                    hold_set   = 1'b1;
                    next_state = HOLD;
                end
                // The EX write owns the port whenever it is accepted here.
                if (rbus_acc) begin
                    wen_raw   = 1'b1;
                    waddr_raw = rbus_wb_dst_reg;
                    wdata_raw = rbus_wb_data;
                end
            end
            HOLD: begin
                wen_raw    = 1'b1;
                waddr_raw  = ld_dst;
                wdata_raw  = hold_data;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // x0 writes are dropped and outputs stay quiet while reset is held.
    assign wen_ok           = wen_raw & (waddr_raw != 5'd0) & cpurst_b;
    assign wb_rf_wen        = wen_ok;
    assign wb_rf_waddr      = wen_ok ? waddr_raw : 5'd0;
    assign wb_rf_wdata      = wen_ok ? wdata_raw : 32'd0;
    assign wb_acc_err_pulse = err_raw & cpurst_b;
    assign wb_ld_pending    = (state != IDLE);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state     <= IDLE;
            ld_dst    <= 5'd0;
            hold_data <= 32'd0;
        end else begin
            state <= next_state;
            if (ld_dst_set)
                ld_dst <= rbus_wb_dst_reg;
            if (hold_set)
                hold_data <= lsu_wb_data;
        end
    end

endmodule

// File: tb/tb_cr_iu_wb_arb.sv
// Self-checking bench for cr_iu_wb_arb: per-cycle expected outputs are
// queued as stimulus is applied and popped when the outputs are sampled.
module tb_cr_iu_wb_arb;

    logic        forever_cpuclk;
    logic        cpurst_b;
    logic        rbus_wb_cmplt;
    logic [31:0] rbus_wb_data;
    logic [4:0]  rbus_wb_dst_reg;
    logic        rbus_wb_load;
    logic        ex_inst_vld;
    logic        ex_rs1_vld;
    logic        ex_rs2_vld;
    logic        ex_rd_vld;
    logic [4:0]  ex_rs1_reg;
    logic [4:0]  ex_rs2_reg;
    logic        lsu_wb_data_vld;
    logic [31:0] lsu_wb_data;
    logic        lsu_wb_acc_err;
    logic        wb_rf_wen;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic        wb_ex_stall;
    logic        wb_ld_pending;
    logic        wb_acc_err_pulse;

    int checks = 0;
    int failures = 0;
    logic [40:0] exp_q[$];
    logic [40:0] got;
    logic [40:0] want;

    typedef struct packed {
        logic        cmplt;
        logic [31:0] data;
        logic [4:0]  dst;
        logic        load;
        logic        inst_vld;
        logic        rs1v;
        logic [4:0]  rs1;
        logic        rs2v;
        logic [4:0]  rs2;
        logic        rdv;
        logic        lvld;
        logic [31:0] ldata;
        logic        lerr;
    } stim_t;

    cr_iu_wb_arb dut (
        .forever_cpuclk   (forever_cpuclk),
        .cpurst_b         (cpurst_b),
        .rbus_wb_cmplt    (rbus_wb_cmplt),
        .rbus_wb_data     (rbus_wb_data),
        .rbus_wb_dst_reg  (rbus_wb_dst_reg),
        .rbus_wb_load     (rbus_wb_load),
        .ex_inst_vld      (ex_inst_vld),
        .ex_rs1_vld       (ex_rs1_vld),
        .ex_rs2_vld       (ex_rs2_vld),
        .ex_rd_vld        (ex_rd_vld),
        .ex_rs1_reg       (ex_rs1_reg),
        .ex_rs2_reg       (ex_rs2_reg),
        .lsu_wb_data_vld  (lsu_wb_data_vld),
        .lsu_wb_data      (lsu_wb_data),
        .lsu_wb_acc_err   (lsu_wb_acc_err),
        .wb_rf_wen        (wb_rf_wen),
        .wb_rf_waddr      (wb_rf_waddr),
        .wb_rf_wdata      (wb_rf_wdata),
        .wb_ex_stall      (wb_ex_stall),
        .wb_ld_pending    (wb_ld_pending),
        .wb_acc_err_pulse (wb_acc_err_pulse)
    );

    initial begin
        forever_cpuclk = 1'b0;
        forever #5 forever_cpuclk = ~forever_cpuclk;
    end

    function automatic logic [40:0] exp_v(input logic wen, input logic [4:0] a,
                                          input logic [31:0] d, input logic st,
                                          input logic pend, input logic err);
        return {wen, a, d, st, pend, err};
    endfunction

    function automatic logic [40:0] observed();
        return {wb_rf_wen, wb_rf_waddr, wb_rf_wdata, wb_ex_stall, wb_ld_pending, wb_acc_err_pulse};
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t ex_wr(input logic [4:0] dst, input logic [31:0] data);
        stim_t s;
        s = '0;
        s.cmplt = 1'b1;
        s.dst = dst;
        s.data = data;
        return s;
    endfunction

    function automatic stim_t fast_ld(input logic [4:0] dst);
        stim_t s;
        s = ex_wr(dst, 32'hFFFF_0000);
        s.load = 1'b1;
        s.inst_vld = 1'b1;
        return s;
    endfunction

    function automatic stim_t with_ret(input stim_t base, input logic [31:0] d, input logic err);
        stim_t s;
        s = base;
        s.lvld = 1'b1;
        s.ldata = d;
        s.lerr = err;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rbus_wb_cmplt   = s.cmplt;
        rbus_wb_data    = s.data;
        rbus_wb_dst_reg = s.dst;
        rbus_wb_load    = s.load;
        ex_inst_vld     = s.inst_vld;
        ex_rs1_vld      = s.rs1v;
        ex_rs1_reg      = s.rs1;
        ex_rs2_vld      = s.rs2v;
        ex_rs2_reg      = s.rs2;
        ex_rd_vld       = s.rdv;
        lsu_wb_data_vld = s.lvld;
        lsu_wb_data     = s.ldata;
        lsu_wb_acc_err  = s.lerr;
    endtask

    task automatic test_reset();
        drive(ex_wr(5'd5, 32'h1234_5678));
        exp_q.push_back(exp_v(0, 0, 0, 0, 0, 0));
        @(negedge forever_cpuclk);
        got = observed();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", got, want);
        end
        drive(nop());
        cpurst_b = 1'b1;
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic test_ex_write();
        stim_t s[2];
        logic [40:0] e[2];
        s[0] = ex_wr(5'd5, 32'h1234_5678); e[0] = exp_v(1, 5, 32'h1234_5678, 0, 0, 0);
        s[1] = ex_wr(5'd0, 32'hCAFE_0000); e[1] = exp_v(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge forever_cpuclk);
            got = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL ex_write step %0d: got %h expected %h", i, got, want);
            end
            @(posedge forever_cpuclk);
            #1;
        end
    endtask

    task automatic test_load();
        stim_t s[5];
        logic [40:0] e[5];
        s[0] = fast_ld(5'd7);                         e[0] = exp_v(0, 0, 0, 0, 0, 0);
        s[1] = nop();                                 e[1] = exp_v(0, 0, 0, 0, 1, 0);
        s[2] = nop();                                 e[2] = exp_v(0, 0, 0, 0, 1, 0);
        s[3] = with_ret(nop(), 32'hDEAD_BEEF, 0);     e[3] = exp_v(1, 7, 32'hDEAD_BEEF, 0, 1, 0);
        s[4] = nop();                                 e[4] = exp_v(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge forever_cpuclk);
            got = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL load step %0d: got %h expected %h", i, got, want);
            end
            @(posedge forever_cpuclk);
            #1;
        end
    endtask

    task automatic test_conflict();
        stim_t s[4];
        logic [40:0] e[4];
        s[0] = fast_ld(5'd7);                                e[0] = exp_v(0, 0, 0, 0, 0, 0);
        s[1] = with_ret(ex_wr(5'd3, 32'h11), 32'hA5A5_A5A5, 0); e[1] = exp_v(1, 3, 32'h11, 0, 1, 0);
        s[2] = ex_wr(5'd4, 32'h22);                          e[2] = exp_v(1, 7, 32'hA5A5_A5A5, 1, 1, 0);
        s[3] = ex_wr(5'd4, 32'h22);                          e[3] = exp_v(1, 4, 32'h22, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge forever_cpuclk);
            got = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL conflict step %0d: got %h expected %h", i, got, want);
            end
            @(posedge forever_cpuclk);
            #1;
        end
    endtask

    task automatic test_hazard();
        stim_t s[9];
        logic [40:0] e[9];
        stim_t raw;
        stim_t waw;
        stim_t other;
        raw = ex_wr(5'd10, 32'h1);
        raw.inst_vld = 1'b1; raw.rs2v = 1'b1; raw.rs2 = 5'd7;
        waw = ex_wr(5'd7, 32'h2);
        waw.inst_vld = 1'b1; waw.rdv = 1'b1;
        other = ex_wr(5'd8, 32'h3);
        other.inst_vld = 1'b1; other.rs1v = 1'b1; other.rs1 = 5'd8;
        s[0] = fast_ld(5'd7);                   e[0] = exp_v(0, 0, 0, 0, 0, 0);
        s[1] = raw;                             e[1] = exp_v(0, 0, 0, 1, 1, 0);
        s[2] = with_ret(raw, 32'h77, 0);        e[2] = exp_v(1, 7, 32'h77, 1, 1, 0);
        s[3] = raw;                             e[3] = exp_v(1, 10, 32'h1, 0, 0, 0);
        s[4] = fast_ld(5'd7);                   e[4] = exp_v(0, 0, 0, 0, 0, 0);
        s[5] = waw;                             e[5] = exp_v(0, 0, 0, 1, 1, 0);
        s[6] = other;                           e[6] = exp_v(1, 8, 32'h3, 0, 1, 0);
        s[7] = with_ret(nop(), 32'h99, 0);      e[7] = exp_v(1, 7, 32'h99, 0, 1, 0);
        s[8] = nop();                           e[8] = exp_v(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge forever_cpuclk);
            got = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL hazard step %0d: got %h expected %h", i, got, want);
            end
            @(posedge forever_cpuclk);
            #1;
        end
    endtask

    task automatic test_acc_err();
        stim_t s[6];
        logic [40:0] e[6];
        s[0] = fast_ld(5'd9);                          e[0] = exp_v(0, 0, 0, 0, 0, 0);
        s[1] = fast_ld(5'd12);                         e[1] = exp_v(0, 0, 0, 1, 1, 0);
        s[2] = with_ret(fast_ld(5'd12), 32'h5, 1);     e[2] = exp_v(0, 0, 0, 1, 1, 1);
        s[3] = fast_ld(5'd12);                         e[3] = exp_v(0, 0, 0, 0, 0, 0);
        s[4] = with_ret(nop(), 32'hC, 0);              e[4] = exp_v(1, 12, 32'hC, 0, 1, 0);
        s[5] = nop();                                  e[5] = exp_v(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge forever_cpuclk);
            got = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL acc_err step %0d: got %h expected %h", i, got, want);
            end
            @(posedge forever_cpuclk);
            #1;
        end
    endtask

    task automatic test_reset_hold();
        stim_t s[2];
        logic [40:0] e[2];
        s[0] = fast_ld(5'd7);                                   e[0] = exp_v(0, 0, 0, 0, 0, 0);
        s[1] = with_ret(ex_wr(5'd3, 32'h11), 32'hA5A5_A5A5, 0); e[1] = exp_v(1, 3, 32'h11, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge forever_cpuclk);
            got = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL reset_hold step %0d: got %h expected %h", i, got, want);
            end
            @(posedge forever_cpuclk);
            #1;
        end
        // Now in HOLD with the x7 write on the port; reset must clear it at once.
        drive(nop());
        cpurst_b = 1'b0;
        exp_q.push_back(exp_v(0, 0, 0, 0, 0, 0));
        #1;
        got = observed();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL reset_in_hold: got %h expected %h", got, want);
        end
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exp_v(0, 0, 0, 0, 0, 0));
            @(negedge forever_cpuclk);
            got = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL after_reset step %0d: got %h expected %h", i, got, want);
            end
            @(posedge forever_cpuclk);
            #1;
        end
    endtask

    task automatic test_x0_load();
        stim_t s[5];
        logic [40:0] e[5];
        s[0] = fast_ld(5'd0);                   e[0] = exp_v(0, 0, 0, 0, 0, 0);
        s[1] = nop();                           e[1] = exp_v(0, 0, 0, 0, 1, 0);
        s[2] = with_ret(nop(), 32'hFF, 0);      e[2] = exp_v(0, 0, 0, 0, 1, 0);
        s[3] = nop();                           e[3] = exp_v(0, 0, 0, 0, 0, 0);
        s[4] = ex_wr(5'd6, 32'h6);              e[4] = exp_v(1, 6, 32'h6, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge forever_cpuclk);
            got = observed();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL x0_load step %0d: got %h expected %h", i, got, want);
            end
            @(posedge forever_cpuclk);
            #1;
        end
    endtask

    initial begin
        cpurst_b = 1'b0;
        drive(nop());
        #12;
        test_reset();
        test_ex_write();
        test_load();
        test_conflict();
        test_hazard();
        test_acc_err();
        test_reset_hold();
        test_x0_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
